// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (iterative double-dabble,
// one input bit per clock) with start/busy/done handshake, overflow flag and
// an optional two's-complement input mode selected by BIN2BCD_SIGNED_EN.
// The cycle after the start edge is already in SHIFT. The final shift lands
// on edge WIDTH, and done is high in the following cycle. A consumer
// sampling on rising edges therefore sees done WIDTH+1 edges after start.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  neg
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic                load;
  logic [WIDTH-1:0]    opnd;
  logic [4*DIGITS-1:0] acc;
  logic [CW-1:0]       cnt;
  logic                sticky;
  logic                neg_lat;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_shift;
  logic                ovf_shift;
  logic [WIDTH-1:0]    magnitude;
  logic                sign_in;

  // Operand conditioning at accept: magnitude and sign of the input
  always_comb begin
`ifdef BIN2BCD_SIGNED_EN
    sign_in   = binary[WIDTH-1];
    magnitude = sign_in ? (WIDTH'(0) - binary) : binary;
`else
    sign_in   = 1'b0;
    magnitude = binary;
`endif
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next bit
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[4*DIGITS-2:0], opnd[WIDTH-1]};
    ovf_shift = sticky | acc_adj[4*DIGITS-1];
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: load, shift, and capture of the result on the last shift
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      neg_lat <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      neg     <= 1'b0;
    end else if (load) begin
      opnd    <= magnitude;
      acc     <= '0;
      sticky  <= 1'b0;
      cnt     <= CW'(WIDTH);
      neg_lat <= sign_in;
    end else if (state == SHIFT) begin
      opnd   <= opnd << 1;
      acc    <= acc_shift;
      sticky <= ovf_shift;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bcd <= acc_shift;
        ovf <= ovf_shift;
        neg <= neg_lat;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed, table-driven bench for bin2bcd_seq (defaults
// WIDTH=14, DIGITS=4). Signed-mode vectors are used when BIN2BCD_SIGNED_EN
// is defined.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] binary = '0;
  logic        busy, done, ovf, neg;
  logic [15:0] bcd;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic        neg;
  } vec_t;

  vec_t vecs[$];

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .binary(binary),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .neg(neg)
  );

  always #5 clk = ~clk;

  // Count done pulses as a synchronous consumer would see them
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start one conversion; lat = edges from the start edge to the edge that
  // samples done high; busy_cycles = cycles with busy high meanwhile.
  task automatic convert(input logic [13:0] val, output int lat, output int busy_cycles);
    @(negedge clk);
    binary = val;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    binary = ~val;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      tick(1);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, d0;
    int t[3];
    int nt;
    logic [15:0] first_bcd;

`ifdef BIN2BCD_SIGNED_EN
    vecs.push_back('{14'd42,    16'h0042, 1'b0, 1'b0});
    vecs.push_back('{14'h3FD6,  16'h0042, 1'b0, 1'b1});
    vecs.push_back('{14'h2000,  16'h8192, 1'b0, 1'b1});
    vecs.push_back('{14'h3FFF,  16'h0001, 1'b0, 1'b1});
    vecs.push_back('{14'h1FFF,  16'h8191, 1'b0, 1'b0});
    vecs.push_back('{14'd1255,  16'h1255, 1'b0, 1'b0});
`else
    vecs.push_back('{14'd10,    16'h0010, 1'b0, 1'b0});
    vecs.push_back('{14'd15,    16'h0015, 1'b0, 1'b0});
    vecs.push_back('{14'd255,   16'h0255, 1'b0, 1'b0});
    vecs.push_back('{14'd1255,  16'h1255, 1'b0, 1'b0});
    vecs.push_back('{14'd9999,  16'h9999, 1'b0, 1'b0});
    vecs.push_back('{14'd10000, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{14'd16383, 16'h6383, 1'b1, 1'b0});
`endif

    // Reset state
    tick(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd",  {16'd0, bcd},  32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_neg",  {31'd0, neg},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero: latency and busy length
    convert(14'd0, lat, bc);
    check("zero_latency", lat, 32'd15);
    check("zero_busy_cycles", bc, 32'd14);
    check("zero_bcd", {16'd0, bcd}, 32'h0000);
    check("zero_ovf", {31'd0, ovf}, 32'd0);
    tick(1);
    check("zero_done_single", {31'd0, done}, 32'd0);

    // Table sweep
    foreach (vecs[i]) begin
      convert(vecs[i].bin, lat, bc);
      check($sformatf("vec%0d_latency", i), lat, 32'd15);
      check($sformatf("vec%0d_bcd", i), {16'd0, bcd}, {16'd0, vecs[i].bcd});
      check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("vec%0d_neg", i), {31'd0, neg}, {31'd0, vecs[i].neg});
      tick(2);
      check($sformatf("vec%0d_hold_bcd", i), {16'd0, bcd}, {16'd0, vecs[i].bcd});
    end

    // Start pulsed mid-conversion is ignored
    d0 = done_cnt;
    @(negedge clk);
    binary = 14'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(4);
    @(negedge clk);
    binary = 14'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick(1);
      lat++;
    end
    check("ignore_done_seen", {31'd0, done}, 32'd1);
    first_bcd = bcd;
    check("ignore_bcd", {16'd0, first_bcd}, 32'h1234);
    tick(25);
    check("ignore_single_done", done_cnt - d0, 32'd1);

    // Start held high: back-to-back results 15 cycles apart
    @(negedge clk);
    binary = 14'd7;
    start = 1'b1;
    nt = 0;
    for (int c = 0; c < 80 && nt < 3; c++) begin
      tick(1);
      if (done) begin
        t[nt] = c;
        nt++;
      end
    end
    check("b2b_pulses", nt, 32'd3);
    check("b2b_period_1", t[1] - t[0], 32'd15);
    check("b2b_period_2", t[2] - t[1], 32'd15);
    check("b2b_bcd", {16'd0, bcd}, 32'h0007);
    @(negedge clk);
    start = 1'b0;
    tick(20);

    // Reset mid-conversion aborts with cleared outputs and no done
    @(negedge clk);
    binary = 14'd555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(6);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    check("abort_bcd_before", {16'd0, bcd}, 32'h0007);
    @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    tick(1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_bcd", {16'd0, bcd}, 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    check("abort_no_done", done_cnt - d0, 32'd0);
    convert(14'd42, lat, bc);
    check("after_abort_latency", lat, 32'd15);
    check("after_abort_bcd", {16'd0, bcd}, 32'h0042);
    check("after_abort_ovf", {31'd0, ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
